// File: rtl/vga_pmod_pkg.sv
// VGA PMOD link constants: default 640x480@60 timing, PMOD bit positions, colour struct.
// Pure declarations, no clocked logic.
package vga_pmod_pkg;

    localparam int   H_ACTIVE_DEF = 640;
    localparam int   H_FRONT_DEF  = 16;
    localparam int   H_SYNC_DEF   = 96;
    localparam int   H_BACK_DEF   = 48;
    localparam int   V_ACTIVE_DEF = 480;
    localparam int   V_FRONT_DEF  = 10;
    localparam int   V_SYNC_DEF   = 2;
    localparam int   V_BACK_DEF   = 33;
    localparam logic SYNC_POL_DEF = 1'b0;

    localparam int PMOD_HSYNC = 7;
    localparam int PMOD_B0    = 6;
    localparam int PMOD_G0    = 5;
    localparam int PMOD_R0    = 4;
    localparam int PMOD_VSYNC = 3;
    localparam int PMOD_B1    = 2;
    localparam int PMOD_G1    = 1;
    localparam int PMOD_R1    = 0;

    typedef struct packed {
        logic [1:0] b;
        logic [1:0] g;
        logic [1:0] r;
    } rgb_t;

    function automatic logic [7:0] pmod_pack(input logic hs, input logic vs, input rgb_t c);
        logic [7:0] p;
        p             = '0;
        p[PMOD_HSYNC] = hs;
        p[PMOD_B0]    = c.b[0];
        p[PMOD_G0]    = c.g[0];
        p[PMOD_R0]    = c.r[0];
        p[PMOD_VSYNC] = vs;
        p[PMOD_B1]    = c.b[1];
        p[PMOD_G1]    = c.g[1];
        p[PMOD_R1]    = c.r[1];
        return p;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus sync/active/line/frame decode; decodes are combinational from the counters.
// Counters advance only on enabled cycles and hold otherwise.
module vga_timing_gen
    import vga_pmod_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FRONT  = H_FRONT_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BACK   = H_BACK_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FRONT  = V_FRONT_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BACK   = V_BACK_DEF,
    parameter logic SYNC_POL = SYNC_POL_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pix_en,
    output logic [9:0] o_hpos,
    output logic [9:0] o_vpos,
    output logic       o_active,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_line_start,
    output logic       o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 || H_TOTAL > 1024) begin : g_bad_h
            $error("vga_timing_gen: illegal horizontal timing");
        end
        if (V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 || V_TOTAL > 1024) begin : g_bad_v
            $error("vga_timing_gen: illegal vertical timing");
        end
    endgenerate

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [9:0] r_hpos;
    logic [9:0] r_vpos;
    logic       w_h_wrap;
    logic       w_v_wrap;

    assign w_h_wrap = (r_hpos == H_LAST);
    assign w_v_wrap = (r_vpos == V_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hpos <= '0;
            r_vpos <= '0;
        end else if (i_pix_en) begin
            r_hpos <= w_h_wrap ? '0 : r_hpos + 10'd1;
            if (w_h_wrap) begin
                r_vpos <= w_v_wrap ? '0 : r_vpos + 10'd1;
            end
        end
    end

    assign o_hpos        = r_hpos;
    assign o_vpos        = r_vpos;
    assign o_active      = (r_hpos < H_VIS) && (r_vpos < V_VIS);
    assign o_hsync       = ((r_hpos >= H_SYNC_BEG) && (r_hpos < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    assign o_vsync       = ((r_vpos >= V_SYNC_BEG) && (r_vpos < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    assign o_line_start  = (r_hpos == '0) && i_pix_en;
    assign o_frame_start = (r_hpos == '0) && (r_vpos == '0) && i_pix_en;

endmodule

// File: rtl/vga_pmod_tx.sv
// VGA PMOD transmitter: raster timing, blanking and a registered PMOD byte (one enabled cycle latency).
// pix_en is a clock enable; with it low, counters and pmod_out hold.
module vga_pmod_tx
    import vga_pmod_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FRONT  = H_FRONT_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BACK   = H_BACK_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FRONT  = V_FRONT_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BACK   = V_BACK_DEF,
    parameter logic SYNC_POL = SYNC_POL_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic [5:0] rgb_in,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       active,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] pmod_out
);

    localparam logic [7:0] PMOD_IDLE = pmod_pack(~SYNC_POL, ~SYNC_POL, '0);

    logic       w_hsync;
    logic       w_vsync;
    rgb_t       w_colour;
    logic [7:0] r_pmod;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pix_en      (pix_en),
        .o_hpos        (hpos),
        .o_vpos        (vpos),
        .o_active      (active),
        .o_hsync       (w_hsync),
        .o_vsync       (w_vsync),
        .o_line_start  (line_start),
        .o_frame_start (frame_start)
    );

    // Colour is forced to zero outside the visible area so porches/sync never carry pixel data.
    assign w_colour = active ? rgb_t'(rgb_in) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pmod <= PMOD_IDLE;
        end else if (pix_en) begin
            r_pmod <= pmod_pack(w_hsync, w_vsync, w_colour);
        end
    end

    assign pmod_out = r_pmod;

endmodule

// File: tb/tb_vga_pmod_tx.sv
// Directed bench: a reduced-timing instance exercises whole frames, a default instance checks line timing.
module tb_vga_pmod_tx;

    localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
    localparam int S_VA = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_HT = 25, S_VT = 15;
    localparam int D_HT = 800, D_VT = 525;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_en;
    logic [5:0] rgb_in;

    logic [9:0] hpos_s, vpos_s, hpos_d, vpos_d;
    logic       active_s, active_d, ls_s, ls_d, fs_s, fs_d;
    logic [7:0] pmod_s, pmod_d;

    int n_checks = 0;
    int n_errors = 0;
    int mm = 0;
    int mh_s, mv_s, mh_d, mv_d;
    logic [7:0] mp_s, mp_d;
    int ls_cnt, fs_cnt, hs_low, hs_first, vs_low, vs_first;

    always #5 clk = ~clk;

    vga_pmod_tx #(
        .H_ACTIVE (S_HA), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_ACTIVE (S_VA), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .SYNC_POL (1'b0)
    ) dut_s (
        .clk (clk), .rst_n (rst_n), .pix_en (pix_en), .rgb_in (rgb_in),
        .hpos (hpos_s), .vpos (vpos_s), .active (active_s),
        .line_start (ls_s), .frame_start (fs_s), .pmod_out (pmod_s)
    );

    vga_pmod_tx dut_d (
        .clk (clk), .rst_n (rst_n), .pix_en (pix_en), .rgb_in (rgb_in),
        .hpos (hpos_d), .vpos (vpos_d), .active (active_d),
        .line_start (ls_d), .frame_start (fs_d), .pmod_out (pmod_d)
    );

    // PMOD byte for a pixel position, straight from the published bit map.
    function automatic logic [7:0] exp_pmod(input int h, input int v, input logic [5:0] c_in,
                                            input int ha, input int hf, input int hs,
                                            input int va, input int vf, input int vs);
        logic       hsn, vsn;
        logic [5:0] c;
        hsn = (h >= ha + hf && h < ha + hf + hs) ? 1'b0 : 1'b1;
        vsn = (v >= va + vf && v < va + vf + vs) ? 1'b0 : 1'b1;
        c   = (h < ha && v < va) ? c_in : 6'b0;
        return {hsn, c[4], c[2], c[0], vsn, c[5], c[3], c[1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mh_s = 0; mv_s = 0; mh_d = 0; mv_d = 0;
        mp_s = 8'h88; mp_d = 8'h88;
    endtask

    task automatic tick();
        if (rst_n && pix_en) begin
            mp_s = exp_pmod(mh_s, mv_s, rgb_in, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS);
            mp_d = exp_pmod(mh_d, mv_d, rgb_in, 640, 16, 96, 480, 10, 2);
            if (mh_s == S_HT - 1) begin
                mh_s = 0;
                mv_s = (mv_s == S_VT - 1) ? 0 : mv_s + 1;
            end else mh_s++;
            if (mh_d == D_HT - 1) begin
                mh_d = 0;
                mv_d = (mv_d == D_VT - 1) ? 0 : mv_d + 1;
            end else mh_d++;
        end
        @(posedge clk);
        #1;
        if (hpos_s !== 10'(mh_s) || vpos_s !== 10'(mv_s) || pmod_s !== mp_s ||
            hpos_d !== 10'(mh_d) || vpos_d !== 10'(mv_d) || pmod_d !== mp_d) mm++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held: idle byte with both syncs high, counters at origin.
        rst_n = 1'b0; pix_en = 1'b0; rgb_in = 6'h3F;
        model_reset();
        #22;
        chk("rst_pmod_s", 32'(pmod_s), 32'h88);
        chk("rst_pmod_d", 32'(pmod_d), 32'h88);
        chk("rst_hpos_d", 32'(hpos_d), 32'd0);
        chk("rst_vpos_d", 32'(vpos_d), 32'd0);
        chk("rst_ls_noen", 32'(ls_d), 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("hold_hpos_s", 32'(hpos_s), 32'd0);
        chk("hold_pmod_s", 32'(pmod_s), 32'h88);
        chk("hold_fs_s", 32'(fs_s), 32'd0);

        // Free run: one default line and a bit over two reduced frames.
        pix_en = 1'b1;
        #1;
        chk("ls0_d", 32'(ls_d), 32'd1);
        chk("fs0_s", 32'(fs_s), 32'd1);
        ls_cnt = 1; fs_cnt = 1; hs_low = 0; hs_first = 0; vs_low = 0; vs_first = 0;
        for (int i = 1; i <= 800; i++) begin
            tick();
            if (ls_d) ls_cnt++;
            if (fs_s) fs_cnt++;
            if (!pmod_d[7]) begin
                hs_low++;
                if (hs_first == 0) hs_first = i;
            end
            if (i <= 375 && !pmod_s[3]) begin
                vs_low++;
                if (vs_first == 0) vs_first = i;
            end
            if (i == 374) begin
                chk("last_hpos_s", 32'(hpos_s), 32'd24);
                chk("last_vpos_s", 32'(vpos_s), 32'd14);
            end
            if (i == 375) begin
                chk("wrap_hpos_s", 32'(hpos_s), 32'd0);
                chk("wrap_vpos_s", 32'(vpos_s), 32'd0);
            end
            if (i == 639) chk("active_639", 32'(active_d), 32'd1);
            if (i == 640) begin
                chk("active_640", 32'(active_d), 32'd0);
                chk("pmod_x639", 32'(pmod_d), 32'hFF);
            end
            if (i == 641) chk("pmod_x640_blank", 32'(pmod_d), 32'h88);
            if (i == 656) chk("pmod_x655_blank", 32'(pmod_d), 32'h88);
            if (i == 657) chk("pmod_x656_hsync", 32'(pmod_d), 32'h08);
        end
        chk("line_wrap_hpos_d", 32'(hpos_d), 32'd0);
        chk("line_wrap_vpos_d", 32'(vpos_d), 32'd1);
        chk("ls_count_d", 32'(ls_cnt), 32'd2);
        chk("fs_count_s", 32'(fs_cnt), 32'd3);
        chk("hsync_low_len", 32'(hs_low), 32'd96);
        chk("hsync_first", 32'(hs_first), 32'd657);
        chk("vsync_low_len", 32'(vs_low), 32'd50);
        chk("vsync_first", 32'(vs_first), 32'd251);
        chk("model_run", 32'(mm), 32'd0);

        // Mid-frame reset on the reduced instance at (10,3).
        for (int i = 0; i < 35; i++) tick();
        chk("pre_rst_hpos_s", 32'(hpos_s), 32'd10);
        chk("pre_rst_vpos_s", 32'(vpos_s), 32'd3);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_hpos_s", 32'(hpos_s), 32'd0);
        chk("mid_rst_vpos_s", 32'(vpos_s), 32'd0);
        chk("mid_rst_pmod_s", 32'(pmod_s), 32'h88);
        chk("mid_rst_vpos_d", 32'(vpos_d), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("rst_held_hpos_s", 32'(hpos_s), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_fs_s", 32'(fs_s), 32'd1);
        chk("post_rst_fs_d", 32'(fs_d), 32'd1);
        fs_cnt = 0;
        for (int i = 1; i <= 130; i++) begin
            tick();
            if (fs_s) fs_cnt++;
        end
        // rgb 010110: b=01 g=01 r=10 -> {1, b0=1, g0=1, r0=0, 1, b1=0, g1=0, r1=1}
        rgb_in = 6'b010110;
        #1;
        chk("at55_hpos_s", 32'(hpos_s), 32'd5);
        chk("at55_vpos_s", 32'(vpos_s), 32'd5);
        tick();
        chk("pack_s", 32'(pmod_s), 32'hE9);
        chk("pack_d", 32'(pmod_d), 32'hE9);
        rgb_in = 6'b0;
        tick();
        chk("zero_colour_s", 32'(pmod_s), 32'h88);
        rgb_in = 6'h3F;
        for (int i = 133; i <= 375; i++) begin
            tick();
            if (i < 375 && fs_s) fs_cnt++;
        end
        chk("no_extra_fs", 32'(fs_cnt), 32'd0);
        chk("next_fs_s", 32'(fs_s), 32'd1);
        chk("post_rst_hpos_d", 32'(hpos_d), 32'd375);

        // Half-rate enable: reduced line period doubles to 50 clocks.
        rst_n = 1'b0; pix_en = 1'b0;
        #1;
        model_reset();
        tick();
        rst_n = 1'b1;
        ls_cnt = 0;
        for (int i = 0; i <= 100; i++) begin
            pix_en = (i % 2 == 0);
            #1;
            if (ls_s) ls_cnt++;
            if (i == 100) begin
                chk("toggle_hpos_s", 32'(hpos_s), 32'd0);
                chk("toggle_vpos_s", 32'(vpos_s), 32'd2);
                chk("toggle_hpos_d", 32'(hpos_d), 32'd50);
            end
            if (i < 100) tick();
        end
        chk("toggle_ls_count", 32'(ls_cnt), 32'd3);
        chk("model_all", 32'(mm), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
